// File: rtl/wb_arb_pkg.sv
// Shared types and grant encodings for the two-master Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_OWN_M0,
        ARB_OWN_M1
    } arb_state_e;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_mem_arbiter_picker.sv
// Two-way round-robin picker: a lone requester always wins, and contention is
// resolved in favour of the master selected by ptr (0 = M0, 1 = M1).
module rr_picker_2
    import wb_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = GNT_NONE;
        case (req)
            2'b01:   gnt = GNT_M0;
            2'b10:   gnt = GNT_M1;
            2'b11:   gnt = ptr ? GNT_M1 : GNT_M0;
            default: gnt = GNT_NONE;
        endcase
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Shares one Wishbone slave port between instruction fetch (M0) and data (M1)
// with round-robin grant, whole-transaction hold, abort handling and a hung-slave timeout.
module wb_mem_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_data_i,
    output logic [DATA_WIDTH-1:0] m0_data_o,
    output logic                  m0_ack_o,

    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_data_i,
    output logic [DATA_WIDTH-1:0] m1_data_o,
    output logic                  m1_ack_o,

    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_addr_o,
    output logic [DATA_WIDTH-1:0] s_data_o,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_ack_i,

    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    localparam int            CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic          TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CW-1:0] LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    arb_state_e      state;
    logic            ptr;
    logic [CW-1:0]   cnt;
    logic [1:0]      req;
    logic [1:0]      pick;

    logic            own_m0;
    logic            own_m1;
    logic            own;
    logic            sel_cyc;
    logic            sel_stb;
    logic            sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic            aborted;
    logic            acked;
    logic            expired;

    assign req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    rr_picker_2 u_picker (
        .req (req),
        .ptr (ptr),
        .gnt (pick)
    );

    always_comb begin
        own_m0   = (state == ARB_OWN_M0);
        own_m1   = (state == ARB_OWN_M1);
        own      = own_m0 | own_m1;
        sel_cyc  = own_m1 ? m1_cyc_i  : m0_cyc_i;
        sel_stb  = own_m1 ? m1_stb_i  : m0_stb_i;
        sel_we   = own_m1 ? m1_we_i   : m0_we_i;
        sel_addr = own_m1 ? m1_addr_i : m0_addr_i;
        sel_data = own_m1 ? m1_data_i : m0_data_i;
        // A dropped cyc takes precedence: any ack or expiry in that cycle is discarded.
        aborted  = own & ~sel_cyc;
        acked    = own & sel_cyc & s_ack_i;
        expired  = TO_EN & own & sel_cyc & ~s_ack_i & (cnt == LIMIT);
    end

    always_comb begin
        s_cyc_o   = own & sel_cyc & ~expired;
        s_stb_o   = own & sel_stb & ~expired;
        s_we_o    = own & sel_we;
        s_addr_o  = own ? sel_addr : '0;
        s_data_o  = own ? sel_data : '0;
        m0_ack_o  = own_m0 & (acked | expired);
        m1_ack_o  = own_m1 & (acked | expired);
        m0_data_o = (own_m0 & ~expired) ? s_data_i : '0;
        m1_data_o = (own_m1 & ~expired) ? s_data_i : '0;
        grant_o   = {own_m1, own_m0};
        timeout_o = expired;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            ptr   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    cnt <= '0;
                    if (pick == GNT_M0) begin
                        state <= ARB_OWN_M0;
                    end else if (pick == GNT_M1) begin
                        state <= ARB_OWN_M1;
                    end
                    if (req == 2'b11) begin
                        ptr <= (pick == GNT_M0);
                    end
                end
                default: begin
                    if (aborted | acked | expired) begin
                        state <= ARB_IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Cycle-by-cycle vector bench for wb_mem_arbiter: each row gives the master/slave
// inputs for one cycle and the outputs expected while those inputs are applied.
module tb_wb_mem_arbiter;
    import wb_arb_pkg::*;

    localparam logic [31:0] M0_ADDR = 32'h0000_0100;
    localparam logic [31:0] M0_WD   = 32'hAAAA_0000;
    localparam logic [31:0] M1_ADDR = 32'h0000_2000;
    localparam logic [31:0] M1_WD   = 32'h1234_5678;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_cyc_i, m0_stb_i, m0_we_i, m0_ack_o;
    logic [31:0] m0_addr_i, m0_data_i, m0_data_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_ack_o;
    logic [31:0] m1_addr_i, m1_data_i, m1_data_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, timeout_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic [1:0]  grant_o;

    always #5 clk = ~clk;

    wb_mem_arbiter #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_cyc_i  (m0_cyc_i),
        .m0_stb_i  (m0_stb_i),
        .m0_we_i   (m0_we_i),
        .m0_addr_i (m0_addr_i),
        .m0_data_i (m0_data_i),
        .m0_data_o (m0_data_o),
        .m0_ack_o  (m0_ack_o),
        .m1_cyc_i  (m1_cyc_i),
        .m1_stb_i  (m1_stb_i),
        .m1_we_i   (m1_we_i),
        .m1_addr_i (m1_addr_i),
        .m1_data_i (m1_data_i),
        .m1_data_o (m1_data_o),
        .m1_ack_o  (m1_ack_o),
        .s_cyc_o   (s_cyc_o),
        .s_stb_o   (s_stb_o),
        .s_we_o    (s_we_o),
        .s_addr_o  (s_addr_o),
        .s_data_o  (s_data_o),
        .s_data_i  (s_data_i),
        .s_ack_i   (s_ack_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    typedef struct packed {
        logic [1:0]  gnt;
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        a0;
        logic [31:0] d0;
        logic        a1;
        logic [31:0] d1;
        logic        to;
    } out_t;

    typedef struct {
        logic        c0;
        logic        c1;
        logic        ack;
        logic [31:0] sd;
        logic [1:0]  gnt;
        logic        scyc;
        logic        a0;
        logic        a1;
        logic        to;
    } vec_t;

    vec_t vecs[$];
    out_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic out_t model(input vec_t v);
        out_t e;
        e.gnt  = v.gnt;
        e.cyc  = v.scyc;
        e.stb  = v.scyc;
        e.we   = (v.gnt == GNT_M1);
        e.addr = (v.gnt == GNT_M0) ? M0_ADDR : (v.gnt == GNT_M1) ? M1_ADDR : 32'h0;
        e.wdat = (v.gnt == GNT_M0) ? M0_WD   : (v.gnt == GNT_M1) ? M1_WD   : 32'h0;
        e.a0   = v.a0;
        e.d0   = (v.gnt == GNT_M0 && !v.to) ? v.sd : 32'h0;
        e.a1   = v.a1;
        e.d1   = (v.gnt == GNT_M1 && !v.to) ? v.sd : 32'h0;
        e.to   = v.to;
        return e;
    endfunction

    function automatic out_t sample();
        out_t a;
        a.gnt  = grant_o;
        a.cyc  = s_cyc_o;
        a.stb  = s_stb_o;
        a.we   = s_we_o;
        a.addr = s_addr_o;
        a.wdat = s_data_o;
        a.a0   = m0_ack_o;
        a.d0   = m0_data_o;
        a.a1   = m1_ack_o;
        a.d1   = m1_data_o;
        a.to   = timeout_o;
        return a;
    endfunction

    task automatic add(input logic c0, input logic c1, input logic ack, input logic [1:0] gnt,
                       input logic scyc, input logic a0, input logic a1, input logic to);
        vec_t v;
        v.c0   = c0;
        v.c1   = c1;
        v.ack  = ack;
        v.sd   = {16'hD00D, 16'(vecs.size())};
        v.gnt  = gnt;
        v.scyc = scyc;
        v.a0   = a0;
        v.a1   = a1;
        v.to   = to;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic c0, input logic c1, input logic ack, input logic [31:0] sd);
        m0_cyc_i = c0;
        m0_stb_i = c0;
        m1_cyc_i = c1;
        m1_stb_i = c1;
        s_ack_i  = ack;
        s_data_i = sd;
    endtask

    task automatic check(input string name);
        out_t e;
        out_t a;
        a = sample();
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty got=%h", name, a);
        end else begin
            e = sb.pop_front();
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s got=%h want=%h", name, a, e);
            end
        end
    endtask

    initial begin
        m0_we_i   = 1'b0;
        m0_addr_i = M0_ADDR;
        m0_data_i = M0_WD;
        m1_we_i   = 1'b1;
        m1_addr_i = M1_ADDR;
        m1_data_i = M1_WD;

        // M0 read, slave acks two cycles after stb
        add(1, 0, 0, GNT_NONE, 0, 0, 0, 0);
        add(1, 0, 0, GNT_M0,   1, 0, 0, 0);
        add(1, 0, 0, GNT_M0,   1, 0, 0, 0);
        add(1, 0, 1, GNT_M0,   1, 1, 0, 0);
        vecs[3].sd = 32'hCAFE_F00D;
        add(0, 0, 0, GNT_NONE, 0, 0, 0, 0);
        // simultaneous requests alternate M0, M1, M0, M1
        add(1, 1, 0, GNT_NONE, 0, 0, 0, 0);
        add(1, 1, 1, GNT_M0,   1, 1, 0, 0);
        add(1, 1, 0, GNT_NONE, 0, 0, 0, 0);
        add(1, 1, 1, GNT_M1,   1, 0, 1, 0);
        add(1, 1, 0, GNT_NONE, 0, 0, 0, 0);
        add(1, 1, 1, GNT_M0,   1, 1, 0, 0);
        add(1, 1, 0, GNT_NONE, 0, 0, 0, 0);
        // M1 write held until ack, then a stray ack in idle
        add(0, 1, 0, GNT_M1,   1, 0, 0, 0);
        add(0, 1, 0, GNT_M1,   1, 0, 0, 0);
        add(0, 1, 1, GNT_M1,   1, 0, 1, 0);
        add(0, 0, 1, GNT_NONE, 0, 0, 0, 0);
        // M1 abort, then late ack
        add(0, 1, 0, GNT_NONE, 0, 0, 0, 0);
        add(0, 1, 0, GNT_M1,   1, 0, 0, 0);
        add(0, 0, 0, GNT_M1,   0, 0, 0, 0);
        add(0, 0, 1, GNT_NONE, 0, 0, 0, 0);
        // ack coinciding with cyc drop is discarded
        add(0, 1, 0, GNT_NONE, 0, 0, 0, 0);
        add(0, 1, 0, GNT_M1,   1, 0, 0, 0);
        add(0, 0, 1, GNT_M1,   0, 0, 0, 0);
        add(0, 0, 0, GNT_NONE, 0, 0, 0, 0);
        // M0 hangs: forced completion on 8th owned cycle, then pending M1
        add(1, 0, 0, GNT_NONE, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            add(1, 1, 0, GNT_M0, 1, 0, 0, 0);
        end
        add(1, 1, 0, GNT_M0,   0, 1, 0, 1);
        add(0, 1, 0, GNT_NONE, 0, 0, 0, 0);
        add(0, 1, 1, GNT_M1,   1, 0, 1, 0);
        add(0, 0, 0, GNT_NONE, 0, 0, 0, 0);

        // reset held 3 cycles with both masters requesting
        rst_n = 1'b0;
        drive(1, 1, 0, 32'h5555_AAAA);
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            sb.push_back('0);
            check($sformatf("reset%0d", r));
        end
        rst_n = 1'b1;
        drive(0, 0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].c0, vecs[i].c1, vecs[i].ack, vecs[i].sd);
            sb.push_back(model(vecs[i]));
            #1;
            check($sformatf("row%0d", i));
        end

        // reset mid-transaction: grant is abandoned with no ack
        @(negedge clk);
        drive(1, 0, 0, 32'h0);
        @(negedge clk);
        #1;
        sb.push_back(model('{c0: 1'b1, c1: 1'b0, ack: 1'b0, sd: 32'h0, gnt: GNT_M0,
                             scyc: 1'b1, a0: 1'b0, a1: 1'b0, to: 1'b0}));
        check("mid_owned");
        rst_n = 1'b0;
        s_ack_i = 1'b0;
        @(negedge clk);
        drive(1, 0, 1, 32'h0BAD_0BAD);
        #1;
        sb.push_back('0);
        check("mid_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
